// File: rtl/serial_dp_loader.sv
// Serial data-point loader: deserialises LSB-first words into a record buffer
// and writes one complete record per strobe until data_points records are loaded.
module serial_dp_loader #(
    parameter int LENGTH       = 16,
    parameter int MAX_FEATURES = 15,
    parameter int ADDR_WIDTH   = 12,
    parameter int LANES        = 1,
    parameter int FEAT_W       = 4
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 START,
    input  logic [FEAT_W-1:0]                    feat,
    input  logic [ADDR_WIDTH-1:0]                data_points,
    input  logic [LANES-1:0]                     S,
    input  logic                                 S_VALID,
    output logic                                 WR_EN,
    output logic [ADDR_WIDTH-1:0]                WR_ADDR,
    output logic [LENGTH*(MAX_FEATURES+1)-1:0]   WR_DATA,
    output logic                                 BUSY,
    output logic                                 LOAD_DONE,
    output logic                                 ERR
);

    localparam int BEATS  = LENGTH / LANES;
    localparam int WORDS  = MAX_FEATURES + 1;
    localparam int DATA_W = LENGTH * WORDS;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [FEAT_W-1:0]       feat_q, feat_d;
    logic [ADDR_WIDTH-1:0]   points_q, points_d;
    logic [FEAT_W-1:0]       wordIdx_q, wordIdx_d;
    logic [BW-1:0]           beatCnt_q, beatCnt_d;
    logic [ADDR_WIDTH-1:0]   recIdx_q, recIdx_d;
    logic [LENGTH-1:0]       shift_q, shift_d;
    logic                    wrEn_q, wrEn_d;
    logic [ADDR_WIDTH-1:0]   wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0]       wrData_q, wrData_d;
    logic                    loadDone_q, loadDone_d;
    logic                    err_q, err_d;

    logic [LENGTH-1:0]       wordNext;
    logic                    lastBeat;
    logic                    recordsDone;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            feat_q     <= '0;
            points_q   <= '0;
            wordIdx_q  <= '0;
            beatCnt_q  <= '0;
            recIdx_q   <= '0;
            shift_q    <= '0;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            loadDone_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            feat_q     <= feat_d;
            points_q   <= points_d;
            wordIdx_q  <= wordIdx_d;
            beatCnt_q  <= beatCnt_d;
            recIdx_q   <= recIdx_d;
            shift_q    <= shift_d;
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            loadDone_q <= loadDone_d;
            err_q      <= err_d;
        end
    end

    // New lanes enter at the top so the first beat ends up in the low bits.
    always_comb begin
        state_d    = state_q;
        feat_d     = feat_q;
        points_d   = points_q;
        wordIdx_d  = wordIdx_q;
        beatCnt_d  = beatCnt_q;
        recIdx_d   = recIdx_q;
        shift_d    = shift_q;
        wrEn_d     = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        loadDone_d = loadDone_q;
        err_d      = err_q;

        wordNext    = (shift_q >> LANES) | (LENGTH'(S) << (LENGTH - LANES));
        lastBeat    = (beatCnt_q == BW'(BEATS - 1));
        recordsDone = wrEn_q && (recIdx_q == points_q);

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    if ((int'(feat) > MAX_FEATURES) || (data_points == '0)) begin
                        err_d      = 1'b1;
                        loadDone_d = 1'b0;
                    end else begin
                        feat_d     = feat;
                        points_d   = data_points;
                        err_d      = 1'b0;
                        loadDone_d = 1'b0;
                        wrData_d   = '0;
                        wrAddr_d   = '0;
                        wordIdx_d  = feat;
                        beatCnt_d  = '0;
                        recIdx_d   = '0;
                        shift_d    = '0;
                        state_d    = LOAD;
                    end
                end
            end

            LOAD: begin
                // The strobe cycle of the final record must not disturb WR_DATA.
                if (recordsDone) begin
                    state_d = DONE;
                end else if (S_VALID) begin
                    shift_d = wordNext;
                    if (lastBeat) begin
                        beatCnt_d = '0;
                        for (int i = 0; i < WORDS; i++) begin
                            if (int'(wordIdx_q) == i) begin
                                wrData_d[i*LENGTH +: LENGTH] = wordNext;
                            end
                        end
                        if (wordIdx_q == '0) begin
                            wrEn_d    = 1'b1;
                            wrAddr_d  = recIdx_q;
                            recIdx_d  = recIdx_q + ADDR_WIDTH'(1);
                            wordIdx_d = feat_q;
                        end else begin
                            wordIdx_d = wordIdx_q - FEAT_W'(1);
                        end
                    end else begin
                        beatCnt_d = beatCnt_q + BW'(1);
                    end
                end
            end

            DONE: begin
                loadDone_d = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign WR_EN     = wrEn_q;
    assign WR_ADDR   = wrAddr_q;
    assign WR_DATA   = wrData_q;
    assign BUSY      = (state_q == LOAD);
    assign LOAD_DONE = loadDone_q;
    assign ERR       = err_q;

endmodule

// File: doc/serial_dp_loader.md
SERIAL_DP_LOADER -- requirements
Module: serial_dp_loader

Interface
REQ-001 Parameter LENGTH, 16, bits per feature/label word.
REQ-002 Parameter MAX_FEATURES, 15, max feature index; record holds MAX_FEATURES+1 words.
REQ-003 Parameter ADDR_WIDTH, 12, record address and count width.
REQ-004 Parameter LANES, 1, serial bits per beat; LENGTH SHALL be a multiple of LANES.
REQ-005 Parameter FEAT_W, 4, width of the feat input.
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RST  in  1  asynchronous reset, active-high.
REQ-008 START  in  1  one-cycle request that latches feat and data_points and begins a load.
REQ-009 feat  in  FEAT_W  highest word index per record (words per record = feat+1).
REQ-010 data_points  in  ADDR_WIDTH  number of records to load.
REQ-011 S  in  LANES  serial data; lane k carries bit (beat*LANES+k) of the current word.
REQ-012 S_VALID  in  1  S is consumed only in cycles where S_VALID=1.
REQ-013 WR_EN  out  1  one-cycle strobe: complete record on WR_DATA/WR_ADDR.
REQ-014 WR_ADDR  out  ADDR_WIDTH  record index, 0 .. data_points-1.
REQ-015 WR_DATA  out  LENGTH*(MAX_FEATURES+1)  record; word i at bits [i*LENGTH +: LENGTH].
REQ-016 BUSY  out  1  high in LOAD.
REQ-017 LOAD_DONE  out  1  sticky: all records written.
REQ-018 ERR  out  1  sticky: last START rejected.

Function
REQ-019 FSM states IDLE, LOAD, DONE.
REQ-020 IDLE + START with feat>MAX_FEATURES or data_points==0: set ERR, clear LOAD_DONE, stay IDLE.
REQ-021 IDLE + valid START: latch feat and data_points, clear ERR, LOAD_DONE, WR_DATA, all counters; go LOAD next cycle.
REQ-022 START in LOAD or DONE: ignored; latched values unchanged.
REQ-023 Bits LSB-first; LENGTH/LANES accepted beats form one word.
REQ-024 Word order per record: index feat first, down to index 0.
REQ-025 On a word's final beat, word stored into WR_DATA slot of its index at that clock edge.
REQ-026 Slots above feat SHALL remain zero for the whole load.
REQ-027 Final beat of word 0: WR_EN=1 in the next cycle only; WR_ADDR = record index.
REQ-028 WR_DATA stable while WR_EN=1; next record's first word may be written at the end of that cycle.
REQ-029 Record index increments after each WR_EN; word index wraps to feat.
REQ-030 After WR_EN for record data_points-1: go DONE; DONE lasts one cycle, sets LOAD_DONE, returns to IDLE.
REQ-031 S_VALID=0: no counter, shift or buffer change; gaps of any length allowed.
REQ-032 S ignored outside LOAD.
REQ-033 WR_ADDR and WR_DATA hold last values until next valid START.

Reset
REQ-034 RST=1 forces, asynchronously: IDLE, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, LOAD_DONE=0, ERR=0, all counters and shift register 0.
REQ-035 RST mid-LOAD: partial record discarded, no WR_EN; a new START is required after release.

Verification
REQ-036 LENGTH=16, LANES=1, feat=11, data_points=5, S_VALID=1 always -> WR_EN 192 beats apart, WR_ADDR 0..4, word 11 = first received, bits [191:0] match source, bits [255:192]=0, LOAD_DONE after 5th record.
REQ-037 Same data with LANES=4 -> 48 beats per record, WR_DATA identical to REQ-036.
REQ-038 S_VALID pattern 1,0,0,1 repeated -> WR_DATA identical to REQ-036; WR_EN only after 192 valid beats.
REQ-039 MAX_FEATURES=7, START with feat=9 -> ERR=1, BUSY=0, no WR_EN; then START feat=3, data_points=2 -> ERR=0, 2 records of 4 words.
REQ-040 RST pulse after 100 beats of record 0 -> all outputs 0, no WR_EN; new START loads cleanly from WR_ADDR=0.
REQ-041 START asserted during LOAD and during the DONE cycle -> ignored, record count and LOAD_DONE timing unchanged.
